dot_product_engine: RTL and testbench
=====================================

# dot_product_engine

Parametrised, pipelined streaming dot-product unit for the MNIST classifier datapath. Accepts one beat of LANES pixel/weight pairs per cycle under a valid/ready handshake and accumulates VEC_LEN products into one signed fixed-point result. It adds configurable width, depth and lane count, back-pressure on both sides, saturation with a flag, and an optional ReLU. One instance computes one neuron; the layer controller instantiates one per output neuron.

## Interface
- LANES, 28: pairs per beat; VEC_LEN must be a multiple of LANES.
- VEC_LEN, 784: elements per dot product; BEATS = VEC_LEN/LANES.
- PIX_W, 10: pixel width, unsigned integer.
- WT_W, 19: weight width, signed two's complement, WT_FRAC fractional bits.
- WT_FRAC, 16: weight fractional bits.
- OUT_W, 28: result width, signed.
- OUT_FRAC, 16: result fractional bits, ≤ WT_FRAC.
- RELU, 0: 1 clamps negative results to 0.
- clk  in  1  clock, rising edge.
- GlobalReset  in  1  synchronous, active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  engine accepts beat.
- pixels  in  LANES*PIX_W  lane k at [k*PIX_W +: PIX_W].
- weights  in  LANES*WT_W  lane k at [k*WT_W +: WT_W].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- value  out  OUT_W  result, Q(OUT_W-OUT_FRAC).OUT_FRAC.
- sat  out  1  saturation or clamp applied to value.

## Operation
- Beat accepted when in_valid & in_ready at a rising edge; otherwise pixels/weights ignored.
- Products: signed(0,pixel) × weight, width PIX_W+WT_W+1, exact.
- Accumulator: exact, ACC_W = PIX_W+WT_W+1+clog2(VEC_LEN); never wraps.
- Output conversion: arithmetic right shift by WT_FRAC−OUT_FRAC (truncate toward −∞), then saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1]; sat=1 if clipped. If RELU=1 and result <0: value=0, sat=0.
- FSM states: IDLE (no beats yet, in_ready=1), ACCUM (beat count 1..BEATS−1, in_ready=1), DRAIN (final beat accepted, pipeline flushing, in_ready=0), DONE (out_valid=1, in_ready=0).
- Transitions: IDLE→ACCUM on first accepted beat (→DRAIN directly if BEATS=1); ACCUM→DRAIN when beat BEATS accepted; DRAIN→DONE when last product reaches output register; DONE→IDLE on out_valid & out_ready.
- Beat counter wraps to 0 on entering DRAIN; accumulator cleared when a new vector's first beat enters stage 3.
- in_valid gaps (bubbles) anywhere in a vector do not alter the result.
- Reset (GlobalReset=0 at an edge) in any state: discards partial vector, pipeline valids, counter, accumulator.

## Timing
- Reset values: in_ready=0 while GlobalReset=0, 1 from first edge after release; out_valid=0, value=0, sat=0, state IDLE.
- Pipeline: stage 1 registered products; stage 2 registered lane-sum adder tree; stage 3 accumulator; stage 4 saturate/ReLU output register.
- Last beat accepted at edge T → out_valid, value, sat registered at edge T+4.
- value and sat held stable while out_valid=1 & out_ready=0.
- Result accepted at edge U → out_valid=0 and in_ready=1 after U; first beat of next vector accepted no earlier than U+1.
- Throughput: one vector per BEATS+5 cycles with out_ready tied 1.
- in_ready depends only on state (no combinational path from out_ready or in_valid).

## Test plan
- Defaults; weights all 0x08000 (0.5), pixel element i = (i%3)+1, 28 beats back-to-back -> value=0x30F8000 (783.5), sat=0, out_valid exactly 4 cycles after last beat.
- Same stimulus, in_valid deasserted 1 of every 3 cycles -> identical value 0x30F8000; in_ready never falls before last beat.
- Weights 0x70000 (−1.0), pixels 1 -> value=0xCF00000 (−784), sat=0; with RELU=1 -> value=0, sat=0.
- Pixels 1023, weights 0x3FFFF -> value=0x7FFFFFF, sat=1.
- out_ready held 0 for 10 cycles after out_valid -> value/out_valid stable, in_ready=0; on acceptance in_ready=1 next cycle, next vector result correct.
- GlobalReset pulsed low for 1 cycle after 10 beats of vector 1, then full vector 2 -> out_valid=0 during/after reset, single result equal to vector 2 alone.

Source files
------------

// File: rtl/dot_product_engine.sv
// dot_product_engine
// Streaming signed fixed-point dot product for one neuron. Each accepted beat
// carries LANES unsigned pixels and LANES signed weights. Every beat's products
// are summed across lanes and accumulated. After BEATS = VEC_LEN/LANES beats
// the exact sum is shifted to the output format, optionally clamped by ReLU and
// saturated. The result is then held until the consumer takes it.
//
// Ports
//   clk          rising-edge clock
//   GlobalReset  synchronous, active-low reset
//   in_valid     input beat valid
//   in_ready     engine accepts a beat (registered, depends only on state)
//   pixels       LANES x PIX_W unsigned, lane k at [k*PIX_W +: PIX_W]
//   weights      LANES x WT_W signed, lane k at [k*WT_W +: WT_W]
//   out_valid    result valid
//   out_ready    consumer accepts result
//   value        signed result, OUT_FRAC fractional bits
//   sat          result was clipped to the output range
//
// Latency: last beat accepted at edge T -> result registered at edge T+4.
module dot_product_engine #(
   parameter int LANES    = 28,
   parameter int VEC_LEN  = 784,
   parameter int PIX_W    = 10,
   parameter int WT_W     = 19,
   parameter int WT_FRAC  = 16,
   parameter int OUT_W    = 28,
   parameter int OUT_FRAC = 16,
   parameter int RELU     = 0
) (
   input  logic                     clk,
   input  logic                     GlobalReset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*PIX_W-1:0]   pixels,
   input  logic [LANES*WT_W-1:0]    weights,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_W-1:0]         value,
   output logic                     sat
);

   localparam int BEATS  = VEC_LEN / LANES;
   localparam int PROD_W = PIX_W + WT_W + 1;
   localparam int ACC_W  = PROD_W + $clog2(VEC_LEN);
   localparam int SHIFT  = WT_FRAC - OUT_FRAC;
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   // Output range limits, expressed at accumulator width.
   localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

   // Arithmetic shift right: truncates toward minus infinity.
   function automatic logic signed [ACC_W-1:0] shift_floor(input logic signed [ACC_W-1:0] x);
      return x >>> SHIFT;
   endfunction

   // Returns {sat, value}. ReLU takes priority, and a clamp to 0 is not
   // reported as saturation.
   function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] x);
      if (RELU != 0 && x[ACC_W-1]) return '0;
      if (x > MAX_V) return {1'b1, MAX_V[OUT_W-1:0]};
      if (x < MIN_V) return {1'b1, MIN_V[OUT_W-1:0]};
      return {1'b0, x[OUT_W-1:0]};
   endfunction

   state_t           state, state_nxt;
   logic             ready_nxt;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             beat_last;
   logic             res_load;

   logic [PIX_W-1:0]         pix_p0 [LANES];
   logic signed [WT_W-1:0]   wt_p0  [LANES];
   logic                     vld_p0, first_p0, last_p0;
   logic signed [PROD_W-1:0] prod_c  [LANES];
   logic signed [PROD_W-1:0] prod_p1 [LANES];
   logic                     vld_p1, first_p1, last_p1;
   logic signed [ACC_W-1:0]  lane_sum;
   logic signed [ACC_W-1:0]  sum_p2;
   logic                     vld_p2, first_p2, last_p2;
   logic signed [ACC_W-1:0]  acc_p3;
   logic                     vld_p3, last_p3;

   assign accept    = in_valid & in_ready;
   assign beat_last = (cnt == LAST_CNT);
   assign res_load  = vld_p3 & last_p3;
   assign out_valid = (state == DONE);

   // Control FSM: next state and registered in_ready.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = beat_last ? DRAIN : ACCUM;
         ACCUM:   if (accept && beat_last) state_nxt = DRAIN;
         DRAIN:   if (res_load) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      ready_nxt = (state_nxt == IDLE) || (state_nxt == ACCUM);
   end

   always_ff @(posedge clk) begin
      if (!GlobalReset) begin
         state    <= IDLE;
         in_ready <= 1'b0;
         cnt      <= '0;
      end else begin
         state    <= state_nxt;
         in_ready <= ready_nxt;
         if (accept) cnt <= beat_last ? '0 : cnt + CNT_W'(1);
      end
   end

   // Stage 0: capture the accepted beat.
   always_ff @(posedge clk) begin
      if (!GlobalReset) vld_p0 <= 1'b0;
      else              vld_p0 <= accept;
   end

   always_ff @(posedge clk) begin
      first_p0 <= (cnt == '0);
      last_p0  <= beat_last;
      if (accept) begin
         for (int k = 0; k < LANES; k++) begin
            pix_p0[k] <= pixels[k*PIX_W +: PIX_W];
            wt_p0[k]  <= weights[k*WT_W +: WT_W];
         end
      end
   end

   // Stage 1: exact per-lane products, with the pixel zero-extended to signed.
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         prod_c[k] = {{(PROD_W-PIX_W){1'b0}}, pix_p0[k]} *
                     {{(PROD_W-WT_W){wt_p0[k][WT_W-1]}}, wt_p0[k]};
      end
   end

   always_ff @(posedge clk) begin
      if (!GlobalReset) vld_p1 <= 1'b0;
      else              vld_p1 <= vld_p0;
   end

   always_ff @(posedge clk) begin
      first_p1 <= first_p0;
      last_p1  <= last_p0;
      for (int k = 0; k < LANES; k++) prod_p1[k] <= prod_c[k];
   end

   // Stage 2: lane-sum adder tree.
   always_comb begin
      lane_sum = '0;
      for (int k = 0; k < LANES; k++) lane_sum = lane_sum + ACC_W'(prod_p1[k]);
   end

   always_ff @(posedge clk) begin
      if (!GlobalReset) vld_p2 <= 1'b0;
      else              vld_p2 <= vld_p1;
   end

   always_ff @(posedge clk) begin
      first_p2 <= first_p1;
      last_p2  <= last_p1;
      sum_p2   <= lane_sum;
   end

   // Stage 3: accumulator. A vector's first beat overwrites it instead of
   // adding, so no separate clear is needed between vectors.
   always_ff @(posedge clk) begin
      if (!GlobalReset) vld_p3 <= 1'b0;
      else              vld_p3 <= vld_p2;
   end

   always_ff @(posedge clk) begin
      last_p3 <= last_p2;
      if (vld_p2) acc_p3 <= first_p2 ? sum_p2 : acc_p3 + sum_p2;
   end

   // Stage 4: format conversion into the held output register.
   always_ff @(posedge clk) begin
      if (!GlobalReset) begin
         value <= '0;
         sat   <= 1'b0;
      end else if (res_load) begin
         {sat, value} <= saturate(shift_floor(acc_p3));
      end
   end

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench for dot_product_engine. It runs two instances on the same
// stimulus: one with RELU=0 and one with RELU=1. Expected values are
// hand-computed constants.
module tb_dot_product_engine;

   localparam int LANES   = 28;
   localparam int VEC_LEN = 784;
   localparam int PIX_W   = 10;
   localparam int WT_W    = 19;
   localparam int OUT_W   = 28;
   localparam int BEATS   = VEC_LEN / LANES;

   logic                   clk = 1'b0;
   logic                   GlobalReset;
   logic                   in_valid;
   logic                   in_ready, in_ready_r;
   logic [LANES*PIX_W-1:0] pixels;
   logic [LANES*WT_W-1:0]  weights;
   logic                   out_valid, out_valid_r;
   logic                   out_ready;
   logic [OUT_W-1:0]       value, value_r;
   logic                   sat, sat_r;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int lc;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dot_product_engine dut (
      .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(in_ready),
      .pixels(pixels), .weights(weights), .out_valid(out_valid), .out_ready(out_ready),
      .value(value), .sat(sat)
   );

   dot_product_engine #(.RELU(1)) dut_relu (
      .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(in_ready_r),
      .pixels(pixels), .weights(weights), .out_valid(out_valid_r), .out_ready(out_ready),
      .value(value_r), .sat(sat_r)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [PIX_W-1:0] pix_of(input int mode, input int idx);
      case (mode)
         0:       return PIX_W'((idx % 3) + 1);
         1:       return PIX_W'(1);
         default: return PIX_W'(1023);
      endcase
   endfunction

   function automatic logic [WT_W-1:0] wt_of(input int mode);
      case (mode)
         0:       return 19'h08000;
         1:       return 19'h70000;
         2:       return 19'h3FFFF;
         default: return 19'h40000;
      endcase
   endfunction

   task automatic drive_beat(input int mode, input int beat);
      for (int k = 0; k < LANES; k++) begin
         pixels[k*PIX_W +: PIX_W] = pix_of(mode, beat*LANES + k);
         weights[k*WT_W +: WT_W]  = wt_of(mode);
      end
   endtask

   task automatic send_vector(input int mode, input int nbeats, input bit bubbles,
                              output int last_cyc);
      int b = 0;
      int c = 0;
      bit acc;
      bit dropped = 1'b0;
      last_cyc = 0;
      while (b < nbeats && c < 400) begin
         drive_beat(mode, b);
         in_valid = !(bubbles && (c % 3 == 2));
         if (!in_ready) dropped = 1'b1;
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin
            b++;
            last_cyc = cyc;
         end
         c++;
      end
      in_valid = 1'b0;
      check($sformatf("beats_m%0d", mode), b, nbeats);
      check($sformatf("rdy_hold_m%0d", mode), dropped, 0);
      if (nbeats == BEATS) check($sformatf("rdy_drain_m%0d", mode), in_ready, 0);
   endtask

   task automatic get_result(input int last_cyc, input logic [OUT_W-1:0] exp_v, input bit exp_s,
                             input logic [OUT_W-1:0] exp_rv, input bit exp_rs, input int hold);
      int w = 0;
      while (!out_valid && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      check("out_valid", out_valid, 1);
      check("latency", cyc - last_cyc, 4);
      check("value", value, exp_v);
      check("sat", sat, exp_s);
      check("relu_value", value_r, exp_rv);
      check("relu_sat", sat_r, exp_rs);
      if (hold > 0) begin
         out_ready = 1'b0;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_value", value, exp_v);
            check("hold_rdy", in_ready, 0);
         end
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check("accept_valid", out_valid, 0);
      check("accept_rdy", in_ready, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      GlobalReset = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      pixels      = '0;
      weights     = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_value", value, 0);
      check("rst_sat", sat, 0);
      GlobalReset = 1'b1;
      @(posedge clk); #1;
      check("rel_in_ready", in_ready, 1);

      // 1567 pixel sum * 0.5 = 783.5
      send_vector(0, BEATS, 1'b0, lc);
      get_result(lc, 28'h30F8000, 1'b0, 28'h30F8000, 1'b0, 0);

      send_vector(0, BEATS, 1'b1, lc);
      get_result(lc, 28'h30F8000, 1'b0, 28'h30F8000, 1'b0, 0);

      // -784.0; ReLU clamps to zero without flagging
      send_vector(1, BEATS, 1'b0, lc);
      get_result(lc, 28'hCF00000, 1'b0, 28'h0, 1'b0, 0);

      // Large positive overflow
      send_vector(2, BEATS, 1'b0, lc);
      get_result(lc, 28'h7FFFFFF, 1'b1, 28'h7FFFFFF, 1'b1, 0);

      // Large negative overflow
      send_vector(3, BEATS, 1'b0, lc);
      get_result(lc, 28'h8000000, 1'b1, 28'h0, 1'b0, 0);

      // Back-pressure, then a following vector
      send_vector(0, BEATS, 1'b0, lc);
      get_result(lc, 28'h30F8000, 1'b0, 28'h30F8000, 1'b0, 10);
      send_vector(1, BEATS, 1'b0, lc);
      get_result(lc, 28'hCF00000, 1'b0, 28'h0, 1'b0, 0);

      // Reset mid-vector discards the partial vector
      send_vector(2, 10, 1'b0, lc);
      GlobalReset = 1'b0;
      @(posedge clk); #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 0);
      GlobalReset = 1'b1;
      @(posedge clk); #1;
      check("postrst_in_ready", in_ready, 1);
      check("postrst_out_valid", out_valid, 0);
      send_vector(0, BEATS, 1'b0, lc);
      get_result(lc, 28'h30F8000, 1'b0, 28'h30F8000, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
